// File: rtl/noc_network_interface_pkg.sv
// Shared types and header layout for the NoC network interface.
// Holds default widths, header field offsets and the TX/RX state encodings.
package noc_network_interface_pkg;

  localparam int NI_DATA_WIDTH = 16;
  localparam int NI_TX_DEPTH   = 4;
  localparam int NI_NODE_W     = 5;

  localparam int DEST_LSB = 0;
  localparam int SRC_LSB  = NI_NODE_W;
  localparam int SEQ_LSB  = 2 * NI_NODE_W;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_HEAD = 2'd1,
    TX_BODY = 2'd2
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_HEAD    = 2'd0,
    RX_BODY    = 2'd1,
    RX_DISCARD = 2'd2,
    RX_DELIVER = 2'd3
  } rx_state_e;

  function automatic int seq_width(int dw, int nw);
    return dw - 2 * nw;
  endfunction

endpackage

// File: rtl/noc_ni_fifo.sv
// Synchronous FIFO: i_push/i_din write, i_pop/o_dout read (show-ahead),
// o_full/o_empty flags and o_level occupancy. DEPTH must be a power of two.
module noc_ni_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_din,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [LW-1:0]    r_level;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_level == LW'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_dout  = r_mem[r_rptr];

  assign w_pop  = i_pop && !o_empty;
  // A pop frees the slot the push lands in, so full+pop may still push.
  assign w_push = i_push && (!o_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/noc_network_interface.sv
// Per-PE NoC interface: queues PE messages and sends each as head+body
// flits; reassembles head+body flits from the router for the PE.
// Ports: pe_tx_* (PE inject), net_tx_* (to router), net_rx_* (from router),
// pe_rx_* (PE delivery), tx_level, sticky err_proto / err_misroute.
module noc_network_interface
  import noc_network_interface_pkg::*;
#(
  parameter int DATA_WIDTH = NI_DATA_WIDTH,
  parameter int TX_DEPTH   = NI_TX_DEPTH,
  parameter int NODE_W     = NI_NODE_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NODE_W-1:0]         node_id,
  input  logic [DATA_WIDTH-1:0]     pe_tx_data,
  input  logic [NODE_W-1:0]         pe_tx_dest,
  input  logic                      pe_tx_valid,
  output logic                      pe_tx_ready,
  output logic [DATA_WIDTH-1:0]     net_tx_data,
  output logic                      net_tx_head,
  output logic                      net_tx_valid,
  input  logic                      net_tx_ready,
  input  logic [DATA_WIDTH-1:0]     net_rx_data,
  input  logic                      net_rx_head,
  input  logic                      net_rx_valid,
  output logic                      net_rx_ready,
  output logic [DATA_WIDTH-1:0]     pe_rx_data,
  output logic [NODE_W-1:0]         pe_rx_src,
  output logic                      pe_rx_valid,
  input  logic                      pe_rx_ready,
  output logic [$clog2(TX_DEPTH):0] tx_level,
  output logic                      err_proto,
  output logic                      err_misroute
);

  localparam int LVL_W = $clog2(TX_DEPTH) + 1;
  localparam int SEQ_W = seq_width(DATA_WIDTH, NODE_W);
  localparam int FW    = NODE_W + DATA_WIDTH;

  tx_state_e r_tx_state, w_tx_next;
  rx_state_e r_rx_state, w_rx_next;

  logic [SEQ_W-1:0]      r_seq;
  logic [FW-1:0]         w_fifo_dout;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic [NODE_W-1:0]     w_dest;
  logic [DATA_WIDTH-1:0] w_payload;
  logic [DATA_WIDTH-1:0] w_hdr;

  logic [NODE_W-1:0]     r_rx_src;
  logic [DATA_WIDTH-1:0] r_rx_data;
  logic                  r_err_proto;
  logic                  r_err_mis;
  logic [NODE_W-1:0]     w_rx_dest;
  logic                  w_set_proto;
  logic                  w_set_mis;
  logic                  w_lat_src;
  logic                  w_lat_data;

  assign pe_tx_ready = !w_full;
  assign w_push      = pe_tx_valid && !w_full;
  assign w_dest      = w_fifo_dout[FW-1 -: NODE_W];
  assign w_payload   = w_fifo_dout[DATA_WIDTH-1:0];
  assign w_hdr       = {r_seq, node_id, w_dest};

  noc_ni_fifo #(
    .WIDTH (FW),
    .DEPTH (TX_DEPTH)
  ) u_txq (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_din   ({pe_tx_dest, pe_tx_data}),
    .i_pop   (w_pop),
    .o_dout  (w_fifo_dout),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (tx_level)
  );

  // The same-cycle push counts as "pending" so an empty NI starts the
  // head right away and BODY->HEAD never inserts a bubble.
  always_comb begin
    w_tx_next    = r_tx_state;
    net_tx_valid = 1'b0;
    net_tx_head  = 1'b0;
    net_tx_data  = '0;
    w_pop        = 1'b0;
    unique case (r_tx_state)
      TX_IDLE: begin
        if (!w_empty || w_push) w_tx_next = TX_HEAD;
      end
      TX_HEAD: begin
        net_tx_valid = 1'b1;
        net_tx_head  = 1'b1;
        net_tx_data  = w_hdr;
        if (net_tx_ready) w_tx_next = TX_BODY;
      end
      TX_BODY: begin
        net_tx_valid = 1'b1;
        net_tx_data  = w_payload;
        if (net_tx_ready) begin
          w_pop = 1'b1;
          if (tx_level > LVL_W'(1) || w_push)
            w_tx_next = TX_HEAD;
          else
            w_tx_next = TX_IDLE;
        end
      end
      default: w_tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_state <= TX_IDLE;
      r_seq      <= '0;
    end else begin
      r_tx_state <= w_tx_next;
      if (w_pop) r_seq <= r_seq + SEQ_W'(1);
    end
  end

  assign w_rx_dest = net_rx_data[NODE_W-1:0];

  // A head is handled identically in every accepting state; only its
  // arrival outside RX_HEAD is a sequencing error.
  always_comb begin
    w_rx_next    = r_rx_state;
    net_rx_ready = 1'b0;
    pe_rx_valid  = 1'b0;
    w_set_proto  = 1'b0;
    w_set_mis    = 1'b0;
    w_lat_src    = 1'b0;
    w_lat_data   = 1'b0;
    if (r_rx_state == RX_DELIVER) begin
      pe_rx_valid = 1'b1;
      if (pe_rx_ready) w_rx_next = RX_HEAD;
    end else begin
      net_rx_ready = 1'b1;
      if (net_rx_valid && net_rx_head) begin
        w_set_proto = (r_rx_state != RX_HEAD);
        if (w_rx_dest == node_id) begin
          w_lat_src = 1'b1;
          w_rx_next = RX_BODY;
        end else begin
          w_set_mis = 1'b1;
          w_rx_next = RX_DISCARD;
        end
      end else if (net_rx_valid) begin
        unique case (r_rx_state)
          RX_BODY: begin
            w_lat_data = 1'b1;
            w_rx_next  = RX_DELIVER;
          end
          RX_DISCARD: w_rx_next = RX_HEAD;
          default:    w_set_proto = 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_state  <= RX_HEAD;
      r_rx_src    <= '0;
      r_rx_data   <= '0;
      r_err_proto <= 1'b0;
      r_err_mis   <= 1'b0;
    end else begin
      r_rx_state <= w_rx_next;
      if (w_lat_src)
        r_rx_src <= net_rx_data[2*NODE_W-1:NODE_W];
      if (w_lat_data) r_rx_data <= net_rx_data;
      if (w_set_proto) r_err_proto <= 1'b1;
      if (w_set_mis) r_err_mis <= 1'b1;
    end
  end

  assign pe_rx_data   = r_rx_data;
  assign pe_rx_src    = r_rx_src;
  assign err_proto    = r_err_proto;
  assign err_misroute = r_err_mis;

endmodule

// File: tb/tb_noc_network_interface.sv
// Self-checking bench for noc_network_interface (node 3).
// Random traffic on both paths is compared against a message-level model.
module tb_noc_network_interface;

  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int NW    = 5;
  localparam int NODE  = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NW-1:0] node_id;
  logic [DW-1:0] pe_tx_data;
  logic [NW-1:0] pe_tx_dest;
  logic          pe_tx_valid;
  logic          pe_tx_ready;
  logic [DW-1:0] net_tx_data;
  logic          net_tx_head;
  logic          net_tx_valid;
  logic          net_tx_ready;
  logic [DW-1:0] net_rx_data;
  logic          net_rx_head;
  logic          net_rx_valid;
  logic          net_rx_ready;
  logic [DW-1:0] pe_rx_data;
  logic [NW-1:0] pe_rx_src;
  logic          pe_rx_valid;
  logic          pe_rx_ready;
  logic [2:0]    tx_level;
  logic          err_proto;
  logic          err_misroute;

  always #5 clk = ~clk;

  noc_network_interface #(
    .DATA_WIDTH (DW),
    .TX_DEPTH   (DEPTH),
    .NODE_W     (NW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .node_id      (node_id),
    .pe_tx_data   (pe_tx_data),
    .pe_tx_dest   (pe_tx_dest),
    .pe_tx_valid  (pe_tx_valid),
    .pe_tx_ready  (pe_tx_ready),
    .net_tx_data  (net_tx_data),
    .net_tx_head  (net_tx_head),
    .net_tx_valid (net_tx_valid),
    .net_tx_ready (net_tx_ready),
    .net_rx_data  (net_rx_data),
    .net_rx_head  (net_rx_head),
    .net_rx_valid (net_rx_valid),
    .net_rx_ready (net_rx_ready),
    .pe_rx_data   (pe_rx_data),
    .pe_rx_src    (pe_rx_src),
    .pe_rx_valid  (pe_rx_valid),
    .pe_rx_ready  (pe_rx_ready),
    .tx_level     (tx_level),
    .err_proto    (err_proto),
    .err_misroute (err_misroute)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [NW-1:0] dest;
    logic [DW-1:0] data;
  } msg_t;

  typedef struct {
    logic [NW-1:0] src;
    logic [DW-1:0] data;
  } dlv_t;

  msg_t txq[$];
  dlv_t rxq[$];
  int   tx_msgs = 0;
  int   tx_flits = 0;
  bit   m_txh = 1'b1;
  bit   m_prev_head = 1'b0;
  bit   m_pend = 1'b0;
  int   m_src = 0;
  bit   m_proto = 1'b0;
  bit   m_mis = 1'b0;
  bit   p_tv = 1'b0;
  bit   p_tr = 1'b0;
  bit   p_th = 1'b0;
  logic [DW-1:0] p_td = '0;

  function automatic int exp_hdr(int n, int dest);
    return (n % 64) * 1024 + NODE * 32 + dest;
  endfunction

  // Message-level model, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      txq.delete();
      rxq.delete();
      tx_msgs = 0;
      m_txh = 1'b1;
      m_prev_head = 1'b0;
      m_pend = 1'b0;
      m_proto = 1'b0;
      m_mis = 1'b0;
      p_tv = 1'b0;
    end else begin
      check("tx_level", 32'(tx_level), txq.size());
      check("pe_tx_ready", 32'(pe_tx_ready),
            32'(txq.size() < DEPTH));
      check("err_proto", 32'(err_proto), 32'(m_proto));
      check("err_misroute", 32'(err_misroute), 32'(m_mis));
      check("net_rx_ready", 32'(net_rx_ready),
            32'(!pe_rx_valid));
      if (p_tv && !p_tr) begin
        check("tx_hold_valid", 32'(net_tx_valid), 1);
        check("tx_hold_head", 32'(net_tx_head), 32'(p_th));
        check("tx_hold_data", 32'(net_tx_data), 32'(p_td));
      end
      if (net_tx_valid && net_tx_ready) begin
        tx_flits++;
        if (txq.size() == 0) begin
          check("tx_unexpected", 32'(net_tx_valid), 0);
        end else begin
          check("tx_kind", 32'(net_tx_head), 32'(m_txh));
          if (m_txh) begin
            check("tx_header", 32'(net_tx_data),
                  exp_hdr(tx_msgs, int'(txq[0].dest)));
          end else begin
            check("tx_body", 32'(net_tx_data),
                  32'(txq[0].data));
            void'(txq.pop_front());
            tx_msgs++;
          end
          m_txh = !m_txh;
        end
      end
      if (pe_tx_valid && pe_tx_ready) begin
        msg_t m;
        m.dest = pe_tx_dest;
        m.data = pe_tx_data;
        txq.push_back(m);
      end
      check("rx_valid", 32'(pe_rx_valid),
            32'(rxq.size() != 0));
      if (pe_rx_valid && rxq.size() != 0) begin
        check("rx_data", 32'(pe_rx_data), 32'(rxq[0].data));
        check("rx_src", 32'(pe_rx_src), 32'(rxq[0].src));
        if (pe_rx_ready) void'(rxq.pop_front());
      end
      if (net_rx_valid && net_rx_ready) begin
        int dst;
        int src;
        dst = int'(net_rx_data) % 32;
        src = (int'(net_rx_data) / 32) % 32;
        if (net_rx_head) begin
          if (m_prev_head) m_proto = 1'b1;
          if (dst != NODE) begin
            m_mis = 1'b1;
            m_pend = 1'b0;
          end else begin
            m_pend = 1'b1;
            m_src = src;
          end
          m_prev_head = 1'b1;
        end else begin
          if (!m_prev_head) begin
            m_proto = 1'b1;
          end else if (m_pend) begin
            dlv_t d;
            d.src = NW'(m_src);
            d.data = net_rx_data;
            rxq.push_back(d);
          end
          m_prev_head = 1'b0;
          m_pend = 1'b0;
        end
      end
      p_tv = net_tx_valid;
      p_tr = net_tx_ready;
      p_th = net_tx_head;
      p_td = net_tx_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic send_rx(input bit hd, input logic [DW-1:0] d);
    bit ok;
    int n;
    net_rx_valid = 1'b1;
    net_rx_head = hd;
    net_rx_data = d;
    n = 0;
    ok = 1'b0;
    while (!ok && n < 20) begin
      @(negedge clk);
      ok = net_rx_ready;
      tick();
      n++;
    end
    if (!ok) check("rx_accept_timeout", 32'(ok), 1);
    net_rx_valid = 1'b0;
  endtask

  initial begin
    bit f_tx;
    bit f_rx;
    bit want_head;
    int acc;
    int f0;
    int n;

    node_id = NW'(NODE);
    pe_tx_data = '0;
    pe_tx_dest = '0;
    pe_tx_valid = 1'b0;
    net_tx_ready = 1'b0;
    net_rx_data = '0;
    net_rx_head = 1'b0;
    net_rx_valid = 1'b0;
    pe_rx_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #2;
    check("rst_level", 32'(tx_level), 0);
    check("rst_tx_ready", 32'(pe_tx_ready), 1);
    check("rst_rx_ready", 32'(net_rx_ready), 1);
    check("rst_tx_valid", 32'(net_tx_valid), 0);
    check("rst_rx_valid", 32'(pe_rx_valid), 0);
    check("rst_rx_data", 32'(pe_rx_data), 0);
    check("rst_rx_src", 32'(pe_rx_src), 0);
    check("rst_flags", 32'({err_proto, err_misroute}), 0);

    tick();
    pe_tx_valid = 1'b1;
    pe_tx_dest = 5'd7;
    pe_tx_data = 16'h1234;
    net_tx_ready = 1'b1;
    tick();
    pe_tx_valid = 1'b0;
    check("lat_head_valid", 32'(net_tx_valid), 1);
    check("lat_head_flag", 32'(net_tx_head), 1);
    check("lat_head_data", 32'(net_tx_data), 32'h0067);
    tick();
    check("lat_body_valid", 32'(net_tx_valid), 1);
    check("lat_body_flag", 32'(net_tx_head), 0);
    check("lat_body_data", 32'(net_tx_data), 32'h1234);
    tick();
    check("lat_idle", 32'(net_tx_valid), 0);

    do_reset();
    net_tx_ready = 1'b0;
    acc = 0;
    pe_tx_valid = 1'b1;
    pe_tx_data = 16'h0;
    pe_tx_dest = 5'd1;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      f_tx = pe_tx_ready;
      tick();
      if (f_tx) begin
        acc++;
        pe_tx_data = DW'(acc);
        pe_tx_dest = NW'($urandom_range(0, 31));
      end
    end
    check("fill_accepts", acc, 4);
    check("fill_level", 32'(tx_level), 4);
    check("fill_ready_low", 32'(pe_tx_ready), 0);
    net_tx_ready = 1'b1;
    f0 = tx_flits;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      f_tx = pe_tx_valid && pe_tx_ready;
      tick();
      if (f_tx) pe_tx_valid = 1'b0;
    end
    check("drain_no_bubble", tx_flits - f0, 10);
    check("drain_msgs", tx_msgs, 5);
    check("drain_idle", 32'(net_tx_valid), 0);

    pe_rx_ready = 1'b0;
    send_rx(1'b1, 16'h0123);
    send_rx(1'b0, 16'hBEEF);
    check("dlv_valid", 32'(pe_rx_valid), 1);
    check("dlv_data", 32'(pe_rx_data), 32'hBEEF);
    check("dlv_src", 32'(pe_rx_src), 9);
    for (int c = 0; c < 5; c++) begin
      tick();
      check("dlv_hold_ready", 32'(net_rx_ready), 0);
      check("dlv_hold_data", 32'(pe_rx_data), 32'hBEEF);
    end
    pe_rx_ready = 1'b1;
    tick();
    check("dlv_done", 32'(pe_rx_valid), 0);

    send_rx(1'b0, 16'h5555);
    tick();
    check("orphan_proto", 32'(err_proto), 1);
    check("orphan_nodlv", 32'(pe_rx_valid), 0);
    check("orphan_nomis", 32'(err_misroute), 0);
    send_rx(1'b1, 16'h0024);
    send_rx(1'b0, 16'h7777);
    tick();
    check("misroute_flag", 32'(err_misroute), 1);
    check("misroute_drop", 32'(pe_rx_valid), 0);

    pe_tx_valid = 1'b1;
    pe_tx_dest = 5'd5;
    pe_tx_data = 16'hAAAA;
    net_tx_ready = 1'b1;
    tick();
    pe_tx_valid = 1'b0;
    tick();
    net_tx_ready = 1'b0;
    check("pre_rst_body", 32'({net_tx_valid, net_tx_head}), 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_tx_valid", 32'(net_tx_valid), 0);
    check("arst_level", 32'(tx_level), 0);
    check("arst_flags", 32'({err_proto, err_misroute}), 0);
    tick();
    rst_n = 1'b1;

    want_head = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      f_tx = pe_tx_valid && pe_tx_ready;
      f_rx = net_rx_valid && net_rx_ready;
      tick();
      if (!pe_tx_valid || f_tx) begin
        pe_tx_valid = 1'($urandom_range(0, 1));
        pe_tx_data = DW'($urandom);
        pe_tx_dest = NW'($urandom_range(0, 31));
      end
      net_tx_ready = ($urandom_range(0, 3) != 0);
      if (f_rx) want_head = !net_rx_head;
      if (!net_rx_valid || f_rx) begin
        net_rx_valid = 1'($urandom_range(0, 1));
        net_rx_head = ($urandom_range(0, 9) == 0) ?
                      !want_head : want_head;
        if (net_rx_head) begin
          net_rx_data[15:10] = 6'($urandom);
          net_rx_data[9:5] = NW'($urandom);
          net_rx_data[4:0] = ($urandom_range(0, 5) == 0) ?
                             NW'($urandom) : NW'(NODE);
        end else begin
          net_rx_data = DW'($urandom);
        end
      end
      pe_rx_ready = ($urandom_range(0, 2) != 0);
    end
    check("wrap_reached", 32'(tx_msgs > 64), 1);

    net_tx_ready = 1'b1;
    pe_rx_ready = 1'b1;
    n = 0;
    while ((pe_tx_valid || net_rx_valid || txq.size() != 0 ||
            rxq.size() != 0) && n < 100) begin
      @(negedge clk);
      f_tx = pe_tx_valid && pe_tx_ready;
      f_rx = net_rx_valid && net_rx_ready;
      tick();
      if (f_tx) pe_tx_valid = 1'b0;
      if (f_rx) net_rx_valid = 1'b0;
      n++;
    end
    check("final_drain", 32'(txq.size() + rxq.size()), 0);
    tick();
    check("final_tx_idle", 32'(net_tx_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
